shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_reg_core.sv | 28 ++
 rtl/shift_seq_ctrl.sv | 96 +++++++++
 tb/tb_shift_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: command modes and controller states.
package shift_seq_pkg;

  localparam logic [1:0] MODE_LOAD    = 2'b00;
  localparam logic [1:0] MODE_SHIFT   = 2'b01;
  localparam logic [1:0] MODE_RING    = 2'b10;
  localparam logic [1:0] MODE_JOHNSON = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit right-shifting register with parallel load and a registered serial output.
module shift_reg_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             new_bit,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  // Load leaves sout untouched; only a shift updates the serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      sout <= 1'b0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q    <= {new_bit, q[WIDTH-1:1]};
      sout <= q[0];
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command-driven shift sequencer: accepts LOAD/SHIFT/RING/JOHNSON commands and
// steps the shift_reg_core datapath for the requested number of edges.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNTW  = 4
) (
  input  logic             clkIn,
  input  logic             rstN,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [1:0]       cmdMode,
  input  logic [CNTW-1:0]  cmdSteps,
  input  logic [WIDTH-1:0] cmdData,
  input  logic             sinIn,
  input  logic             abortIn,
  output logic [WIDTH-1:0] data,
  output logic             dout,
  output logic             busy,
  output logic             doneOut
);

  localparam logic [CNTW:0] CNT_ONE  = (CNTW+1)'(1);
  localparam logic [CNTW:0] CNT_FULL = {1'b1, {CNTW{1'b0}}};

  state_t           state, state_nxt;
  logic [1:0]       mode_q;
  logic [CNTW:0]    cnt;
  logic [WIDTH-1:0] ld_data;
  logic             accept, do_load, do_shift, new_bit;

  assign accept   = cmdValid && (state == ST_IDLE);
  assign do_load  = (state == ST_LOAD) && !abortIn;
  assign do_shift = (state == ST_RUN)  && !abortIn;

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state  <= ST_IDLE;
      mode_q <= MODE_LOAD;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q <= cmdMode;
        cnt    <= (cmdSteps == '0) ? CNT_FULL : {1'b0, cmdSteps};
      end else if (do_shift) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Load value is only consumed in LOAD, which always follows an accept.
  always_ff @(posedge clkIn) begin
    if (accept) ld_data <= cmdData;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmdValid) state_nxt = (cmdMode == MODE_LOAD) ? ST_LOAD : ST_RUN;
      ST_LOAD: state_nxt = abortIn ? ST_IDLE : ST_DONE;
      ST_RUN: begin
        if (abortIn)            state_nxt = ST_IDLE;
        else if (cnt == CNT_ONE) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    new_bit = sinIn;
    case (mode_q)
      MODE_RING:    new_bit = data[0];
      MODE_JOHNSON: new_bit = ~data[0];
      default:      new_bit = sinIn;
    endcase
  end

  assign cmdReady = (state == ST_IDLE);
  assign busy     = (state == ST_LOAD) || (state == ST_RUN);
  assign doneOut  = (state == ST_DONE);

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clkIn),
    .rst_n    (rstN),
    .load     (do_load),
    .load_val (ld_data),
    .shift_en (do_shift),
    .new_bit  (new_bit),
    .q        (data),
    .sout     (dout)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus randomized commands
// checked against a transaction-level model of the register contents.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clkIn = 1'b0;
  logic          rstN = 1'b0;
  logic          cmdValid = 1'b0;
  logic [1:0]    cmdMode = 2'b00;
  logic [CW-1:0] cmdSteps = '0;
  logic [W-1:0]  cmdData = '0;
  logic          sinIn = 1'b0;
  logic          abortIn = 1'b0;
  logic          cmdReady, dout, busy, doneOut;
  logic [W-1:0]  data;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_data = '0;
  logic         m_dout = 1'b0;

  shift_seq_ctrl #(.WIDTH(W), .CNTW(CW)) dut (
    .clkIn    (clkIn),
    .rstN     (rstN),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdMode  (cmdMode),
    .cmdSteps (cmdSteps),
    .cmdData  (cmdData),
    .sinIn    (sinIn),
    .abortIn  (abortIn),
    .data     (data),
    .dout     (dout),
    .busy     (busy),
    .doneOut  (doneOut)
  );

  always #5 clkIn = ~clkIn;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".data"}, data, m_data);
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".ready"}, cmdReady, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, doneOut, 1'b0);
  endtask

  // One full command: accept edge, then LOAD or N shift edges, then the DONE cycle.
  // abort_at/rst_at select the working edge (1-based) at which abort or reset hits.
  task automatic do_cmd(input logic [1:0] mode, input int steps, input logic [W-1:0] cdata,
                        input int abort_at, input int rst_at,
                        input logic [31:0] sin_pat, input bit sin_rand);
    int   n;
    logic sb, nb;
    n = (steps == 0) ? (1 << CW) : steps;
    chk("pre.ready", cmdReady, 1'b1);
    cmdValid = 1'b1;
    cmdMode  = mode;
    cmdSteps = CW'(steps);
    cmdData  = cdata;
    abortIn  = 1'($urandom_range(0, 1));
    step();
    cmdValid = 1'b0;
    abortIn  = 1'b0;
    cmdMode  = 2'($urandom);
    cmdSteps = CW'($urandom);
    cmdData  = W'($urandom);
    chk("acc.busy", busy, 1'b1);
    chk("acc.ready", cmdReady, 1'b0);
    chk("acc.done", doneOut, 1'b0);
    chk("acc.data", data, m_data);
    if (mode == MODE_LOAD) n = 1;
    for (int k = 1; k <= n; k++) begin
      if (k == rst_at) begin
        #2 rstN = 1'b0;
        #1;
        m_data = '0;
        m_dout = 1'b0;
        chk_idle("rst.async");
        step();
        chk_idle("rst.held");
        rstN = 1'b1;
        return;
      end
      sb = sin_rand ? 1'($urandom) : sin_pat[k-1];
      sinIn   = sb;
      abortIn = (k == abort_at);
      step();
      if (k == abort_at) begin
        abortIn = 1'b0;
        chk_idle("abort");
        return;
      end
      if (mode == MODE_LOAD) begin
        m_data = cdata;
      end else begin
        nb = (mode == MODE_SHIFT) ? sb :
             (mode == MODE_RING)  ? m_data[0] : ~m_data[0];
        m_dout = m_data[0];
        m_data = (m_data >> 1) | (W'(nb) << (W - 1));
      end
      chk("run.data", data, m_data);
      chk("run.dout", dout, m_dout);
      chk("run.done", doneOut, (k == n));
      chk("run.busy", busy, (k != n));
    end
    step();
    chk_idle("post");
  endtask

  initial begin
    logic [1:0] md;
    int         st, ab, nn;

    // Reset state before any clock edge, then asynchronous reset mid-cycle.
    #2;
    chk_idle("reset0");
    rstN = 1'b1;
    step();
    do_cmd(MODE_LOAD, 0, 4'b1011, 0, 0, 0, 1'b1);
    #3 rstN = 1'b0;
    #1;
    m_data = '0;
    m_dout = 1'b0;
    chk_idle("reset.mid");
    step();
    rstN = 1'b1;
    step();
    chk_idle("reset.rel");

    // LOAD 1000 then RING x4: 0100 0010 0001 1000, dout 0 0 0 1.
    do_cmd(MODE_LOAD, 0, 4'b1000, 0, 0, 0, 1'b1);
    chk("load.value", data, 4'b1000);
    do_cmd(MODE_RING, 4, '0, 0, 0, 0, 1'b1);
    chk("ring.final", data, 4'b1000);
    chk("ring.dout", dout, 1'b1);

    // JOHNSON x8 from 0000 returns to 0000.
    do_cmd(MODE_LOAD, 0, 4'b0000, 0, 0, 0, 1'b1);
    do_cmd(MODE_JOHNSON, 8, '0, 0, 0, 0, 1'b1);
    chk("johnson.final", data, 4'b0000);

    // SHIFT x3 with sin 1,0,1 -> 1010; then steps=0 runs 16 shifts.
    do_cmd(MODE_SHIFT, 3, '0, 0, 0, 32'b101, 1'b0);
    chk("shift.final", data, 4'b1010);
    do_cmd(MODE_SHIFT, 0, '0, 0, 0, 0, 1'b1);

    // LOAD 1000, RING x4 aborted after first shift: frozen at 0100.
    do_cmd(MODE_LOAD, 0, 4'b1000, 0, 0, 0, 1'b1);
    do_cmd(MODE_RING, 4, '0, 2, 0, 0, 1'b1);
    chk("abort.frozen", data, 4'b0100);
    step();
    chk_idle("abort.idle");

    // Abort during LOAD keeps previous contents.
    do_cmd(MODE_LOAD, 0, 4'b0011, 1, 0, 0, 1'b1);
    chk("abortload.hold", data, 4'b0100);

    // JOHNSON x5 reset after 2 shifts, then LOAD 0110 completes normally.
    do_cmd(MODE_JOHNSON, 5, '0, 0, 3, 0, 1'b1);
    do_cmd(MODE_LOAD, 0, 4'b0110, 0, 0, 0, 1'b1);
    chk("afterrst.load", data, 4'b0110);

    // Randomized commands with occasional aborts and idle gaps.
    for (int i = 0; i < 60; i++) begin
      md = 2'($urandom_range(0, 3));
      st = $urandom_range(0, 15);
      nn = (md == MODE_LOAD) ? 1 : ((st == 0) ? 16 : st);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nn) : 0;
      do_cmd(md, st, W'($urandom), ab, 0, 0, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        abortIn = 1'($urandom);
        step();
        abortIn = 1'b0;
        chk_idle("gap");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
